// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs, pipeline-register enables/bubbles, multi-cycle handshake.
// Latency: none (wires only); CNT_W sizes StallCycles and must match the controller's CNT_W.
// Backpressure: none; stalls are expressed through the PcWrite/IfIdWrite/IdExWrite enables.
//  master: pipeline side, drives hazard inputs and McDone/StallClr, receives controls.
//  slave : hazard_stall_ctrl side.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IfIdRs1Add;
    logic [4:0]       IfIdRs2Add;
    logic             IfIdUsesRs1;
    logic             IfIdUsesRs2;
    logic             IdExMemRead;
    logic [4:0]       IdExRdAdd;
    logic             IdExMultiCycle;
    logic             BranchTaken;
    logic             McDone;
    logic             StallClr;
    logic             PcWrite;
    logic             IfIdWrite;
    logic             IdExWrite;
    logic             IfIdFlush;
    logic             IdExBubble;
    logic             ExMemBubble;
    logic             McStart;
    logic             McError;
    logic [CNT_W-1:0] StallCycles;
    logic [1:0]       State;

    modport master (
        output IfIdRs1Add, IfIdRs2Add, IfIdUsesRs1, IfIdUsesRs2, IdExMemRead, IdExRdAdd,
               IdExMultiCycle, BranchTaken, McDone, StallClr,
        input  PcWrite, IfIdWrite, IdExWrite, IfIdFlush, IdExBubble, ExMemBubble,
               McStart, McError, StallCycles, State
    );

    modport slave (
        input  IfIdRs1Add, IfIdRs2Add, IfIdUsesRs1, IfIdUsesRs2, IdExMemRead, IdExRdAdd,
               IdExMultiCycle, BranchTaken, McDone, StallClr,
        output PcWrite, IfIdWrite, IdExWrite, IfIdFlush, IdExBubble, ExMemBubble,
               McStart, McError, StallCycles, State
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer: load-use stall, taken-branch flush, multi-cycle EX wait with timeout, stall counter.
// Latency: enables/bubbles/McStart are combinational (same cycle); State/McError/StallCycles registered.
// Backpressure: holds PC, IF/ID and ID/EX while a load-use or multi-cycle op is pending; MC_ERR holds forever.
//  Ports: Clk, Rst_n (synchronous, active-low) plus hsc (hazard_stall_ctrl_if.slave).
module hazard_stall_ctrl #(
    parameter int CNT_W      = 16,
    parameter int MC_TIMEOUT = 64
) (
    input logic             Clk,
    input logic             Rst_n,
    hazard_stall_ctrl_if.slave hsc
);
    localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MC_WAIT = 2'b01,
        MC_ERR  = 2'b10
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic              mcError;
    logic [CNT_W-1:0]  stallCycles;

    logic loadUse;
    logic pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExBubble, exMemBubble, mcStart;

    // rd=x0 never creates a dependency; unused operand fields are don't-care.
    assign loadUse = hsc.IdExMemRead && (hsc.IdExRdAdd != 5'd0) &&
                     ((hsc.IfIdUsesRs1 && (hsc.IfIdRs1Add == hsc.IdExRdAdd)) ||
                      (hsc.IfIdUsesRs2 && (hsc.IfIdRs2Add == hsc.IdExRdAdd)));

    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExBubble  = 1'b0;
        exMemBubble = 1'b0;
        mcStart     = 1'b0;
        nextState   = RUN;
        case (state)
            MC_WAIT: begin
                if (hsc.McDone) begin
                    nextState = RUN;
                end else begin
                    pcWrite     = 1'b0;
                    ifIdWrite   = 1'b0;
                    idExWrite   = 1'b0;
                    exMemBubble = 1'b1;
                    nextState   = (waitCnt == WAIT_LAST) ? MC_ERR : MC_WAIT;
                end
            end
            MC_ERR: begin
                pcWrite     = 1'b0;
                ifIdWrite   = 1'b0;
                idExWrite   = 1'b0;
                exMemBubble = 1'b1;
                nextState   = MC_ERR;
            end
            default: begin
                // Branch wins over load-use: the dependent instruction is being flushed anyway.
                if (hsc.BranchTaken) begin
                    ifIdFlush  = 1'b1;
                    idExBubble = 1'b1;
                end else if (hsc.IdExMultiCycle) begin
                    mcStart     = 1'b1;
                    pcWrite     = 1'b0;
                    ifIdWrite   = 1'b0;
                    idExWrite   = 1'b0;
                    exMemBubble = 1'b1;
                    nextState   = MC_WAIT;
                end else if (loadUse) begin
                    // One bubble only: next cycle the bubble sits in EX so the hazard cannot re-fire.
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state       <= RUN;
            waitCnt     <= '0;
            mcError     <= 1'b0;
            stallCycles <= '0;
        end else begin
            state <= nextState;
            if (state != MC_WAIT) begin
                waitCnt <= '0;
            end else if (!hsc.McDone && (waitCnt != WAIT_LAST)) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (nextState == MC_ERR) begin
                mcError <= 1'b1;
            end
            if (hsc.StallClr) begin
                stallCycles <= '0;
            end else if (!pcWrite && (stallCycles != {CNT_W{1'b1}})) begin
                stallCycles <= stallCycles + 1'b1;
            end
        end
    end

    assign hsc.PcWrite     = pcWrite;
    assign hsc.IfIdWrite   = ifIdWrite;
    assign hsc.IdExWrite   = idExWrite;
    assign hsc.IfIdFlush   = ifIdFlush;
    assign hsc.IdExBubble  = idExBubble;
    assign hsc.ExMemBubble = exMemBubble;
    assign hsc.McStart     = mcStart;
    assign hsc.McError     = mcError;
    assign hsc.StallCycles = stallCycles;
    assign hsc.State       = state;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances share stimulus (A: CNT_W=16/MC_TIMEOUT=64, B: CNT_W=4/MC_TIMEOUT=8).
// Expected results are queued when a step is driven and checked on the following falling edge.
// Each step checks one instance; the stall counter expectation comes from a small saturating model.
module tb_hazard_stall_ctrl;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       memRead;
        logic [4:0] rd;
        logic       mc;
        logic       br;
        logic       done;
        logic       clr;
    } in_t;

    typedef struct {
        int          id;
        bit          sel;
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    // Control order: {PcWrite, IfIdWrite, IdExWrite, IfIdFlush, IdExBubble, ExMemBubble, McStart}
    localparam logic [6:0] CTL_RUN  = 7'b111_0000;
    localparam logic [6:0] CTL_BR   = 7'b111_1100;
    localparam logic [6:0] CTL_LU   = 7'b001_0100;
    localparam logic [6:0] CTL_MCS  = 7'b000_0011;
    localparam logic [6:0] CTL_HOLD = 7'b000_0010;
    localparam in_t IDLE = '0;
    localparam bit DA = 1'b0;
    localparam bit DB = 1'b1;

    in_t  cur = '0;
    exp_t sb[$];
    exp_t e;
    int   nTests = 0;
    int   nFail = 0;
    int   stepId = 0;
    int   expCntA = 0;
    int   expCntB = 0;

    hazard_stall_ctrl_if #(.CNT_W(16)) ifA ();
    hazard_stall_ctrl_if #(.CNT_W(4))  ifB ();

    assign ifA.IfIdRs1Add = cur.rs1;     assign ifB.IfIdRs1Add = cur.rs1;
    assign ifA.IfIdRs2Add = cur.rs2;     assign ifB.IfIdRs2Add = cur.rs2;
    assign ifA.IfIdUsesRs1 = cur.u1;     assign ifB.IfIdUsesRs1 = cur.u1;
    assign ifA.IfIdUsesRs2 = cur.u2;     assign ifB.IfIdUsesRs2 = cur.u2;
    assign ifA.IdExMemRead = cur.memRead; assign ifB.IdExMemRead = cur.memRead;
    assign ifA.IdExRdAdd = cur.rd;       assign ifB.IdExRdAdd = cur.rd;
    assign ifA.IdExMultiCycle = cur.mc;  assign ifB.IdExMultiCycle = cur.mc;
    assign ifA.BranchTaken = cur.br;     assign ifB.BranchTaken = cur.br;
    assign ifA.McDone = cur.done;        assign ifB.McDone = cur.done;
    assign ifA.StallClr = cur.clr;       assign ifB.StallClr = cur.clr;

    hazard_stall_ctrl #(.CNT_W(16), .MC_TIMEOUT(64)) dutA (.Clk(Clk), .Rst_n(Rst_n), .hsc(ifA));
    hazard_stall_ctrl #(.CNT_W(4),  .MC_TIMEOUT(8))  dutB (.Clk(Clk), .Rst_n(Rst_n), .hsc(ifB));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        nTests++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge Clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.sel == DA) begin
                chk($sformatf("s%0d.A.ctl", e.id), {9'b0, ifA.PcWrite, ifA.IfIdWrite, ifA.IdExWrite,
                    ifA.IfIdFlush, ifA.IdExBubble, ifA.ExMemBubble, ifA.McStart}, {9'b0, e.ctl});
                chk($sformatf("s%0d.A.state", e.id), {14'b0, ifA.State}, {14'b0, e.st});
                chk($sformatf("s%0d.A.mcError", e.id), {15'b0, ifA.McError}, {15'b0, e.err});
                chk($sformatf("s%0d.A.stallCycles", e.id), ifA.StallCycles, e.cnt);
            end else begin
                chk($sformatf("s%0d.B.ctl", e.id), {9'b0, ifB.PcWrite, ifB.IfIdWrite, ifB.IdExWrite,
                    ifB.IfIdFlush, ifB.IdExBubble, ifB.ExMemBubble, ifB.McStart}, {9'b0, e.ctl});
                chk($sformatf("s%0d.B.state", e.id), {14'b0, ifB.State}, {14'b0, e.st});
                chk($sformatf("s%0d.B.mcError", e.id), {15'b0, ifB.McError}, {15'b0, e.err});
                chk($sformatf("s%0d.B.stallCycles", e.id), {12'b0, ifB.StallCycles}, e.cnt);
            end
        end
    end

    // Drive one cycle of inputs, queue the expectation, then advance the counter model across the edge.
    task automatic step(input in_t i, input logic [6:0] ctl, input logic [1:0] st, input logic err,
                        input bit sel);
        exp_t x;
        cur = i;
        stepId++;
        x.id  = stepId;
        x.sel = sel;
        x.ctl = ctl;
        x.st  = st;
        x.err = err;
        x.cnt = 16'(sel ? expCntB : expCntA);
        sb.push_back(x);
        @(posedge Clk);
        if (sel == DA) begin
            if (i.clr) expCntA = 0;
            else if (!ctl[6] && expCntA < 65535) expCntA++;
        end else begin
            if (i.clr) expCntB = 0;
            else if (!ctl[6] && expCntB < 15) expCntB++;
        end
        #1;
    endtask

    task automatic doReset();
        cur = IDLE;
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        expCntA = 0;
        expCntB = 0;
    endtask

    function automatic in_t luIn(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2);
        in_t r;
        r = IDLE;
        r.memRead = 1'b1;
        r.rd  = rd;
        r.rs1 = rs1;
        r.u1  = u1;
        r.rs2 = rs2;
        r.u2  = u2;
        return r;
    endfunction

    initial begin
        in_t x;
        doReset();
        // Reset state, both instances
        step(IDLE, CTL_RUN, 2'b00, 1'b0, DA);
        step(IDLE, CTL_RUN, 2'b00, 1'b0, DB);

        // Load-use on rs1: one stall cycle, then free-running
        step(luIn(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), CTL_LU, 2'b00, 1'b0, DA);
        step(IDLE, CTL_RUN, 2'b00, 1'b0, DA);

        // rd=x0 and unused rs2 never stall; used rs2 does
        step(luIn(5'd0, 5'd0, 1'b1, 5'd0, 1'b1), CTL_RUN, 2'b00, 1'b0, DA);
        step(luIn(5'd7, 5'd3, 1'b1, 5'd7, 1'b0), CTL_RUN, 2'b00, 1'b0, DA);
        step(luIn(5'd7, 5'd3, 1'b1, 5'd7, 1'b1), CTL_LU, 2'b00, 1'b0, DA);

        // Branch with a load-use match: flush wins, no stall counted
        x = luIn(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        x.br = 1'b1;
        step(x, CTL_BR, 2'b00, 1'b0, DA);
        step(IDLE, CTL_RUN, 2'b00, 1'b0, DA);

        // Multi-cycle op, done after 10 wait cycles; branch/load-use ignored while waiting
        x = IDLE;
        x.mc = 1'b1;
        step(x, CTL_MCS, 2'b00, 1'b0, DA);
        for (int k = 0; k < 10; k++) begin
            x = IDLE;
            if (k == 3) begin
                x = luIn(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
                x.br = 1'b1;
            end
            if (k == 5) x.mc = 1'b1;
            step(x, CTL_HOLD, 2'b01, 1'b0, DA);
        end
        x = IDLE;
        x.done = 1'b1;
        step(x, CTL_RUN, 2'b01, 1'b0, DA);
        step(IDLE, CTL_RUN, 2'b00, 1'b0, DA);
        step(x, CTL_RUN, 2'b00, 1'b0, DA);
        step(IDLE, CTL_RUN, 2'b00, 1'b0, DA);

        // Reset while waiting returns to RUN with no new start
        doReset();
        x = IDLE;
        x.mc = 1'b1;
        step(x, CTL_MCS, 2'b00, 1'b0, DA);
        step(IDLE, CTL_HOLD, 2'b01, 1'b0, DA);
        step(IDLE, CTL_HOLD, 2'b01, 1'b0, DA);
        doReset();
        step(IDLE, CTL_RUN, 2'b00, 1'b0, DA);

        // Timeout on the MC_TIMEOUT=8 instance: 8 wait cycles, then sticky error
        doReset();
        x = IDLE;
        x.mc = 1'b1;
        step(x, CTL_MCS, 2'b00, 1'b0, DB);
        for (int k = 0; k < 8; k++) step(IDLE, CTL_HOLD, 2'b01, 1'b0, DB);
        step(IDLE, CTL_HOLD, 2'b10, 1'b1, DB);
        x = IDLE;
        x.done = 1'b1;
        step(x, CTL_HOLD, 2'b10, 1'b1, DB);
        x = IDLE;
        x.mc = 1'b1;
        step(x, CTL_HOLD, 2'b10, 1'b1, DB);
        doReset();
        step(IDLE, CTL_RUN, 2'b00, 1'b0, DB);

        // 4-bit counter saturates at 15; clear wins over a stalled cycle
        for (int k = 0; k < 20; k++) step(luIn(5'd2, 5'd2, 1'b1, 5'd0, 1'b0), CTL_LU, 2'b00, 1'b0, DB);
        x = luIn(5'd2, 5'd2, 1'b1, 5'd0, 1'b0);
        x.clr = 1'b1;
        step(x, CTL_LU, 2'b00, 1'b0, DB);
        step(IDLE, CTL_RUN, 2'b00, 1'b0, DB);

        @(negedge Clk);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
